// File: rtl/pc_step_controller.sv
// Front-panel sequencer for the program counter's increment input.
// Synchronises and debounces STEP and RUN/STOP, then issues one pc_inc pulse per
// manual step or one pulse every RUN_DIV cycles while running.
// Optional build macro PC_CTRL_HALT_AT_END_EN: run mode stops (and flags halted)
// instead of wrapping the PC past LAST_ADDR.
module pc_step_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned RUN_DIV         = 8,
  parameter int unsigned LAST_ADDR       = 5
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_btn_step,
  input  logic       i_btn_run,
  input  logic [4:0] i_pc_address,
  output logic       o_pc_inc,
  output logic       o_mode_run,
  output logic       o_wrap,
  output logic       o_halted,
  output logic [7:0] o_step_count
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int unsigned DivW = (RUN_DIV > 2) ? $clog2(RUN_DIV) : 1;
  localparam logic [CntW-1:0] CntLast  = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DivW-1:0] DivLast  = DivW'(RUN_DIV - 1);
  localparam logic [4:0]      LastAddr = 5'(LAST_ADDR);

  typedef enum logic [1:0] {StIdle, StStep, StRun} state_e;

  // Bit 0 is STEP, bit 1 is RUN/STOP.
  logic [1:0]      w_raw;
  logic [1:0]      r_sync1, r_sync2, r_deb, r_deb_prev;
  logic [CntW-1:0] r_cnt [2];
  logic            w_step_press, w_run_press;

  state_e          r_state, w_state_next;
  logic [DivW-1:0] r_div, w_div_next;
  logic            w_tick, w_pulse, w_at_end, w_halt_now;
  logic            r_pc_inc, r_wrap;
  logic [7:0]      r_step_count;
`ifdef PC_CTRL_HALT_AT_END_EN
  logic            r_halted, w_halted_next;
  // Set when run restarts from a halt so the first tick wraps instead of halting again.
  logic            r_resume;
`endif

  assign w_raw        = {i_btn_run, i_btn_step};
  assign w_step_press = r_deb[0] & ~r_deb_prev[0];
  assign w_run_press  = r_deb[1] & ~r_deb_prev[1];
  assign w_tick       = (r_div == DivLast);
  assign w_at_end     = (i_pc_address == LastAddr);

`ifdef PC_CTRL_HALT_AT_END_EN
  assign w_halt_now = w_tick & w_at_end & ~r_resume;
`else
  assign w_halt_now = 1'b0;
`endif

  // Two-flop synchronisers and per-button debounce counters.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_deb      <= '0;
      r_deb_prev <= '0;
      r_cnt[0]   <= '0;
      r_cnt[1]   <= '0;
    end else begin
      r_sync1    <= w_raw;
      r_sync2    <= r_sync1;
      r_deb_prev <= r_deb;
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CntLast) begin
          r_deb[i] <= ~r_deb[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= StIdle;
    else         r_state <= w_state_next;
  end

  // FSM next state; run press outranks a same-cycle step press.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle: begin
        if (w_run_press)       w_state_next = StRun;
        else if (w_step_press) w_state_next = StStep;
      end
      StStep: w_state_next = w_run_press ? StRun : StIdle;
      StRun: begin
        if (w_run_press || w_halt_now) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  // FSM outputs: pulse decision, divider and halt flag next values.
  always_comb begin
    w_pulse    = 1'b0;
    w_div_next = '0;
`ifdef PC_CTRL_HALT_AT_END_EN
    w_halted_next = r_halted;
    if (w_step_press || w_run_press) w_halted_next = 1'b0;
`endif
    case (r_state)
      StIdle: w_pulse = w_step_press & ~w_run_press;
      StRun: begin
        // A stop press discards any tick due in the same cycle.
        if (!w_run_press) begin
          if (w_tick) begin
`ifdef PC_CTRL_HALT_AT_END_EN
            if (w_halt_now) w_halted_next = 1'b1;
`endif
            w_pulse = ~w_halt_now;
          end else begin
            w_div_next = r_div + 1'b1;
          end
        end
      end
      default: w_pulse = 1'b0;
    endcase
  end

  // Registered pulse, wrap flag, divider and saturating step counter.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_div        <= '0;
      r_pc_inc     <= 1'b0;
      r_wrap       <= 1'b0;
      r_step_count <= '0;
    end else begin
      r_div    <= w_div_next;
      r_pc_inc <= w_pulse;
      r_wrap   <= w_pulse & w_at_end;
      if (w_pulse && (r_step_count != 8'hFF)) r_step_count <= r_step_count + 8'd1;
    end
  end

`ifdef PC_CTRL_HALT_AT_END_EN
  // Sticky halt flag and one-shot resume permission after a halt.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_halted <= 1'b0;
      r_resume <= 1'b0;
    end else begin
      r_halted <= w_halted_next;
      if (r_state != StRun && w_state_next == StRun) r_resume <= r_halted;
      else if (r_state == StRun && w_tick)           r_resume <= 1'b0;
    end
  end
  assign o_halted = r_halted;
`else
  assign o_halted = 1'b0;
`endif

  assign o_pc_inc     = r_pc_inc;
  assign o_wrap       = r_wrap;
  assign o_mode_run   = (r_state == StRun);
  assign o_step_count = r_step_count;

endmodule

// File: tb/tb_pc_step_controller.sv
// Scoreboard bench for pc_step_controller (DEBOUNCE_CYCLES=4, RUN_DIV=8, LAST_ADDR=5).
module tb_pc_step_controller;
  localparam int unsigned DB = 4;
  localparam int unsigned RD = 8;
  localparam int unsigned LA = 5;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_step, btn_run;
  logic [4:0] pc_address;
  logic       pc_inc, mode_run, wrap, halted;
  logic [7:0] step_count;

  pc_step_controller #(
    .DEBOUNCE_CYCLES(DB),
    .RUN_DIV        (RD),
    .LAST_ADDR      (LA)
  ) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_btn_step  (btn_step),
    .i_btn_run   (btn_run),
    .i_pc_address(pc_address),
    .o_pc_inc    (pc_inc),
    .o_mode_run  (mode_run),
    .o_wrap      (wrap),
    .o_halted    (halted),
    .o_step_count(step_count)
  );

  always #5 clk = ~clk;

  // Posedge count; at a negedge it equals the number of edges seen so far.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Environment PC register.
  always @(posedge clk or posedge reset) begin
    if (reset)       pc_address <= 5'd0;
    else if (pc_inc) pc_address <= (pc_address == 5'(LA)) ? 5'd0 : pc_address + 5'd1;
  end

  typedef struct {
    int   cyc;
    logic wrap;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int exp_pc = 0;
  int t0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected pulse at negedge count c; wrap follows the expected PC value.
  task automatic push_pulse(input int c);
    exp_t e;
    e.cyc  = c;
    e.wrap = (exp_pc == LA);
    exp_q.push_back(e);
    exp_pc = (exp_pc == LA) ? 0 : exp_pc + 1;
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Monitor: every presented pulse is matched against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && pc_inc === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: pc_inc=1 at cycle %0d, required 0", cyc);
      end else begin
        e = exp_q.pop_front();
        chk("pulse_cycle", cyc, e.cyc);
        chk("pulse_wrap", {31'd0, wrap}, {31'd0, e.wrap});
      end
    end else if (!reset && wrap === 1'b1) begin
      checks++;
      errors++;
      $display("FAIL wrap_without_pulse: wrap=1 pc_inc=%b at cycle %0d", pc_inc, cyc);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    btn_step = 1'b0;
    btn_run  = 1'b0;
    #1;
    chk("reset_pc_inc", pc_inc, 0);
    chk("reset_mode_run", mode_run, 0);
    chk("reset_wrap", wrap, 0);
    chk("reset_halted", halted, 0);
    chk("reset_step_count", step_count, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Clean step press: pulse after edge DB+3 from first sample.
    t0 = cyc;
    push_pulse(t0 + 7);
    btn_step = 1'b1;
    wait_to(t0 + 6);
    chk("step_count_before", step_count, 0);
    wait_to(t0 + 20);
    btn_step = 1'b0;
    chk("step_mode_run", mode_run, 0);
    chk("step_count_1", step_count, 1);
    wait_to(t0 + 40);

    // Bouncing press, then stable high, then release with a glitch.
    t0 = cyc;
    push_pulse(t0 + 19);
    for (int t = 0; t < 60; t++) begin
      if (t == 18) chk("bounce_count_pre", step_count, 1);
      btn_step = (t < 12) ? ((t / 2) % 2 == 0) : (t < 30) ? 1'b1 : (t == 36);
      @(negedge clk);
    end
    chk("bounce_count", step_count, 2);

`ifndef PC_CTRL_HALT_AT_END_EN
    // Run mode: 7 ticks before the stop press; step presses ignored while running.
    t0 = cyc;
    for (int k = 1; k <= 7; k++) push_pulse(t0 + 7 + 8 * k);
    for (int t = 0; t < 100; t++) begin
      btn_run  = (t < 20) || (t >= 60 && t < 80);
      btn_step = (t >= 30 && t < 45);
      if (t == 6)  chk("run_mode_pre", mode_run, 0);
      if (t == 7)  chk("run_mode_on", mode_run, 1);
      if (t == 66) chk("run_mode_hold", mode_run, 1);
      if (t == 67) chk("run_mode_off", mode_run, 0);
      @(negedge clk);
    end
    chk("run_count", step_count, 9);

    // Simultaneous step+run presses: run wins, no step pulse.
    t0 = cyc;
    push_pulse(t0 + 15);
    push_pulse(t0 + 23);
    for (int t = 0; t < 60; t++) begin
      btn_step = (t < 15);
      btn_run  = (t < 10) || (t >= 20 && t < 30);
      if (t == 7)  chk("simul_mode_on", mode_run, 1);
      if (t == 27) chk("simul_mode_off", mode_run, 0);
      @(negedge clk);
    end
    chk("simul_count", step_count, 11);
`else
    // Halt at end: run from PC 0 gives 5 pulses then halts; a step then wraps.
    reset = 1'b1;
    exp_pc = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("halt_count_reset", step_count, 0);
    t0 = cyc;
    for (int k = 1; k <= 5; k++) push_pulse(t0 + 7 + 8 * k);
    push_pulse(t0 + 77);
    for (int t = 0; t < 90; t++) begin
      btn_run  = (t < 20);
      btn_step = (t >= 70 && t < 85);
      if (t == 54) chk("halt_mode_pre", mode_run, 1);
      if (t == 54) chk("halt_flag_pre", halted, 0);
      if (t == 55) chk("halt_mode_off", mode_run, 0);
      if (t == 55) chk("halt_flag_set", halted, 1);
      if (t == 76) chk("halt_flag_hold", halted, 1);
      if (t == 77) chk("halt_flag_clr", halted, 0);
      @(negedge clk);
    end
    chk("halt_count", step_count, 6);
`endif

    // Asynchronous reset mid-run, between ticks.
    btn_step = 1'b0;
    t0 = cyc;
    push_pulse(t0 + 15);
    push_pulse(t0 + 23);
    for (int t = 0; t < 28; t++) begin
      btn_run = (t < 10);
      @(negedge clk);
    end
    chk("prereset_mode", mode_run, 1);
    #3;
    reset = 1'b1;
    exp_pc = 0;
    #1;
    chk("areset_pc_inc", pc_inc, 0);
    chk("areset_mode_run", mode_run, 0);
    chk("areset_wrap", wrap, 0);
    chk("areset_halted", halted, 0);
    chk("areset_step_count", step_count, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("post_reset_mode", mode_run, 0);
    chk("post_reset_count", step_count, 0);

    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_step_controller.md
Name: pc_step_controller

Overview:
- Sequencer that drives the program counter's increment control from front-panel buttons.
- Synchronises and debounces two raw buttons: STEP and RUN/STOP toggle.
- Issues exactly one single-cycle `pc_inc` pulse per STEP press in manual mode, or one pulse every RUN_DIV cycles in run mode.
- Sits between the board buttons and the PC; reads the current PC address to flag program wrap.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive clock edges a synchronised button level must differ from the debounced level before it is accepted (≥1).
- RUN_DIV, 8: clock cycles between auto-step pulses in run mode (≥2).
- LAST_ADDR, 5: highest program address; the PC wraps to 0 after it.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- btn_step  in  1  raw STEP button, asynchronous to clk
- btn_run  in  1  raw RUN/STOP toggle button, asynchronous to clk
- pc_address  in  5  current PC value
- pc_inc  out  1  registered one-cycle increment pulse to the PC control input
- mode_run  out  1  1 while in RUN state
- wrap  out  1  registered one-cycle pulse, high together with pc_inc when that increment wraps the PC
- halted  out  1  sticky end-of-program flag (meaningful only with the optional feature; otherwise tied 0)
- step_count  out  8  number of pc_inc pulses since reset, saturating at 255

Behaviour:
- Reset (async, active-high):
  - pc_inc, wrap, mode_run, halted = 0; step_count = 0.
  - Synchronisers, debounced levels, debounce counters and the divider are all cleared.
  - FSM goes to IDLE.
  - Reset mid-pulse or mid-run aborts immediately; no pulse is issued in the cycle after release.
- Synchroniser: 2-flop chain per button.
- Debounce:
  - Per-button counter. It increments each edge that the synced value ≠ debounced level, and clears when they are equal.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
- Press event: debounced level = 1 and the previous cycle's debounced level = 0. Releases generate no event.
- Latency: raw button goes high and stays stable → pc_inc is high after clock edge DEBOUNCE_CYCLES+3, counted from the first edge sampling the high level, for exactly one cycle.
- FSM states:
  - IDLE:
    - run press → RUN, divider cleared, mode_run=1.
    - Otherwise, step press → STEP: pc_inc=1 on the next edge.
    - Run has priority when both presses occur in the same cycle; that step press is dropped.
  - STEP: single cycle; pc_inc=1, then → IDLE.
  - RUN:
    - Divider counts 0..RUN_DIV-1. On the edge after it reaches RUN_DIV-1, pc_inc=1 and the divider wraps to 0.
    - The first pulse occurs RUN_DIV cycles after entering RUN.
    - run press → IDLE; mode_run=0 on the same edge; any pending tick is discarded.
    - Step presses are ignored in RUN.
- wrap: registered alongside pc_inc; 1 iff pc_address == LAST_ADDR in the cycle the pulse is decided.
- step_count: +1 per pc_inc, saturating at 255, no wrap.
- pc_inc is never high on two consecutive cycles (requires RUN_DIV ≥ 2).

Optional Feature:
- Macro: PC_CTRL_HALT_AT_END_EN.
- Defined:
  - In RUN, when a tick is due and pc_address == LAST_ADDR, no pc_inc is issued.
  - FSM → IDLE, mode_run=0, halted=1.
  - halted clears on the next step or run press, or on reset.
  - A run press restarts run mode and the PC continues, wrapping via the next tick.
  - Manual STEP always wraps normally.
- Not defined:
  - Run mode wraps freely and emits wrap pulses.
  - halted is constant 0.

Test Plan:
- Clean step press (DEBOUNCE_CYCLES=4, RUN_DIV=8): btn_step high for 20 cycles → pc_inc high exactly once, after edge 7 from the first high sample; step_count=1; mode_run=0.
- Bounce: btn_step toggles every 2 cycles for 12 cycles, then holds high → exactly one pc_inc; no pulse generated during the bounce; release glitches produce nothing.
- Run mode: run press, hold pc_address model with wrap at 5 → pulses spaced exactly 8 cycles apart. Sixth pulse has wrap=1 (pc_address=5). Second run press → mode_run=0 and no further pulses.
- Simultaneous step+run presses in IDLE → RUN entered, no STEP pulse; step presses during RUN → no extra pulses.
- Reset asserted asynchronously mid-RUN between ticks → all outputs 0 immediately; no pc_inc for 20 cycles after release with buttons idle.
- With PC_CTRL_HALT_AT_END_EN, run from pc_address=0 → 5 pulses, then halted=1, mode_run=0, no sixth pulse. A step press then gives one pc_inc with wrap=1 and halted=0.
